// File: rtl/ampm_pf_issue.sv
// ampm_pf_issue: queues AMPM prefetch candidates and issues one line request per handshake.
// Latency: an accepted candidate reaches pf_vld one cycle later; each later line of the same entry follows on the next pf_rdy.
// Backpressure: cand_rdy drops when the queue is full or flush is high. pf_vld/pf_addr hold steady while pf_rdy is low.
//
// Ports:
//   clk, rst                      sole clock; synchronous active-high reset
//   cand_vld/cand_rdy             candidate handshake carrying cand_zone, cand_map, cand_dir
//   flush                         drops every queued entry (takes effect at the next edge)
//   pf_vld/pf_rdy, pf_addr        prefetch request {zone, line}
//   occ                           number of queued entries
// Build option: define AMPM_PF_DEDUP_EN so that a candidate for a zone already in the queue
// ORs into that entry instead of taking a new slot.
module ampm_pf_issue #(
    parameter int ZONEW = 16,
    parameter int NLINE = 8,
    parameter int DEPTH = 4,
    localparam int LINEW = $clog2(NLINE),
    localparam int PTRW  = $clog2(DEPTH),
    localparam int OCCW  = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cand_vld,
    output logic                   cand_rdy,
    input  logic [ZONEW-1:0]       cand_zone,
    input  logic [NLINE-1:0]       cand_map,
    input  logic                   cand_dir,
    input  logic                   flush,
    output logic                   pf_vld,
    input  logic                   pf_rdy,
    output logic [ZONEW+LINEW-1:0] pf_addr,
    output logic [OCCW-1:0]        occ
);

    logic [ZONEW-1:0] ent_zone [DEPTH];
    logic [NLINE-1:0] ent_map  [DEPTH];
    logic [DEPTH-1:0] ent_dir;
    logic [DEPTH-1:0] ent_vld;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;

    logic [NLINE-1:0] head_map;
    logic [LINEW-1:0] sel_line;
    logic [NLINE-1:0] sel_hot;
    logic [NLINE-1:0] head_map_nxt;
    logic             not_full;
    logic             issue;
    logic             pop;
    logic             acc;
    logic             push;
    logic             hit;
    logic [PTRW-1:0]  hit_idx;
    logic             merge;

    assign head_map = ent_map[rd_ptr];
    assign not_full = occ < OCCW'(DEPTH);

    // Lowest set bit for ascending order, highest for descending. In each loop the
    // last assignment wins, so the loop runs in the direction opposite to the wanted bit.
    always_comb begin
        sel_line = '0;
        if (!ent_dir[rd_ptr]) begin
            for (int i = NLINE - 1; i >= 0; i--)
                if (head_map[i]) sel_line = LINEW'(i);
        end else begin
            for (int i = 0; i < NLINE; i++)
                if (head_map[i]) sel_line = LINEW'(i);
        end
    end

    assign sel_hot      = NLINE'(1) << sel_line;
    assign head_map_nxt = head_map & ~sel_hot;

    // Gating pf_vld with flush and rst makes a handshake impossible in those cycles.
    assign pf_vld  = ent_vld[rd_ptr] & (|head_map) & ~flush & ~rst;
    assign pf_addr = {ent_zone[rd_ptr], sel_line};
    assign issue   = pf_vld & pf_rdy;
    assign pop     = issue & ~(|head_map_nxt);

`ifdef AMPM_PF_DEDUP_EN
    // A head entry that pops this cycle is not a valid merge target. Its slot is about to be freed.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_vld[i] && ent_zone[i] == cand_zone && !(pop && PTRW'(i) == rd_ptr)) begin
                hit     = 1'b1;
                hit_idx = PTRW'(i);
            end
        end
    end
`else
    assign hit     = 1'b0;
    assign hit_idx = '0;
`endif

    assign cand_rdy = ~rst & ~flush & (not_full | hit);
    assign acc      = cand_vld & cand_rdy;
    // An all-zero map is accepted but never allocated.
    assign push     = acc & ~hit & (|cand_map);
    assign merge    = acc & hit & (|cand_map);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_vld <= '0;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            occ     <= '0;
        end else begin
            if (issue) begin
                if (pop) begin
                    ent_vld[rd_ptr] <= 1'b0;
                    rd_ptr          <= rd_ptr + 1'b1;
                end else begin
                    ent_map[rd_ptr] <= head_map_nxt;
                end
            end
            // The merge target can be the head while it issues a bit that does not
            // empty it. Drop that bit here too, so it is not requested a second time.
            if (merge) begin
                if (issue && hit_idx == rd_ptr)
                    ent_map[hit_idx] <= (ent_map[hit_idx] | cand_map) & ~sel_hot;
                else
                    ent_map[hit_idx] <= ent_map[hit_idx] | cand_map;
            end
            if (push) begin
                ent_vld[wr_ptr]  <= 1'b1;
                ent_zone[wr_ptr] <= cand_zone;
                ent_map[wr_ptr]  <= cand_map;
                ent_dir[wr_ptr]  <= cand_dir;
                wr_ptr           <= wr_ptr + 1'b1;
            end
            occ <= occ + OCCW'(push) - OCCW'(pop);
        end
    end

endmodule
